dcache_nway: RTL

// Parametrised write-back, write-allocate data cache. Generalises the fixed 2-way/8-set/2-word L1 dcache.

---
 rtl/dcache_nway_if.sv | 28 ++
 rtl/dcache_nway.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway_if.sv
// Bus bundle between the datapath, dcache_nway and the memory arbiter.
// The cache takes the slave view; the datapath/memory environment takes the master view.
interface dcache_nway_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_nway.sv
// Parametrised write-back, write-allocate data cache with true-LRU ages per set,
// single-pass halt flush and a hit-count write at the end of the flush.
module dcache_nway #(
    parameter int          WAYS    = 2,
    parameter int          SETS    = 8,
    parameter int          WORDS   = 2,
    parameter logic [31:0] HITADDR = 32'h3100
) (
    input logic          CLK,
    input logic          nRST,
    dcache_nway_if.slave dif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int CTR_W = (WORDS > 1) ? OFF_W : 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, HITCNT, DONE} state_t;

    state_t state_q, next_state;

    logic [31:0]      data_q  [SETS][WAYS][WORDS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic             valid_q [SETS][WAYS];
    logic             dirty_q [SETS][WAYS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];

    logic [31:0]      hitcount_q;
    logic             miss_flag_q;
    logic [WAY_W-1:0] victim_q;
    logic [TAG_W-1:0] miss_tag_q;
    logic [IDX_W-1:0] miss_idx_q;
    logic [CTR_W-1:0] ctr_q;
    logic [IDX_W-1:0] fset_q;
    logic [WAY_W-1:0] fway_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [CTR_W-1:0] req_off;
    logic             req;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             found_inv;
    logic             last_word;
    logic             flush_last;
    logic             fdirty;

    function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t,
                                            input logic [IDX_W-1:0] i,
                                            input logic [CTR_W-1:0] c);
        return (32'(t) << (2 + OFF_W + IDX_W)) | (32'(i) << (2 + OFF_W)) | (32'(c) << 2);
    endfunction

    assign req_tag    = TAG_W'(dif.dmemaddr >> (2 + OFF_W + IDX_W));
    assign req_idx    = IDX_W'(dif.dmemaddr >> (2 + OFF_W));
    assign req_off    = CTR_W'(dif.dmemaddr >> 2) & CTR_W'(WORDS - 1);
    assign req        = dif.dmemREN | dif.dmemWEN;
    assign last_word  = (ctr_q == CTR_W'(WORDS - 1));
    assign flush_last = (fset_q == IDX_W'(SETS - 1)) && (fway_q == WAY_W'(WAYS - 1));
    assign fdirty     = dirty_q[fset_q][fway_q];

    // Tag lookup and victim choice: first invalid way, otherwise the oldest way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        victim    = '0;
        found_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !valid_q[req_idx][w]) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= next_state;
    end

    // Next state and bus outputs; requests go quiet whenever the FSM is in IDLE or DONE.
    always_comb begin
        next_state   = state_q;
        dif.dhit     = 1'b0;
        dif.dmemload = '0;
        dif.flushed  = 1'b0;
        dif.dREN     = 1'b0;
        dif.dWEN     = 1'b0;
        dif.daddr    = '0;
        dif.dstore   = '0;
        case (state_q)
            IDLE: begin
                if (dif.halt) begin
                    next_state = FLUSH;
                end else if (req) begin
                    if (hit) begin
                        dif.dhit     = 1'b1;
                        dif.dmemload = data_q[req_idx][hit_way][req_off];
                    end else begin
                        next_state = dirty_q[req_idx][victim] ? WB : FETCH;
                    end
                end
            end
            WB: begin
                dif.dWEN   = 1'b1;
                dif.daddr  = mk_addr(tag_q[miss_idx_q][victim_q], miss_idx_q, ctr_q);
                dif.dstore = data_q[miss_idx_q][victim_q][ctr_q];
                if (!dif.dwait && last_word) next_state = FETCH;
            end
            FETCH: begin
                dif.dREN  = 1'b1;
                dif.daddr = mk_addr(miss_tag_q, miss_idx_q, ctr_q);
                if (!dif.dwait && last_word) next_state = IDLE;
            end
            FLUSH: begin
                if (fdirty) begin
                    dif.dWEN   = 1'b1;
                    dif.daddr  = mk_addr(tag_q[fset_q][fway_q], fset_q, ctr_q);
                    dif.dstore = data_q[fset_q][fway_q][ctr_q];
                    if (!dif.dwait && last_word && flush_last) next_state = HITCNT;
                end else if (flush_last) begin
                    next_state = HITCNT;
                end
            end
            HITCNT: begin
                dif.dWEN   = 1'b1;
                dif.daddr  = HITADDR;
                dif.dstore = hitcount_q;
                if (!dif.dwait) next_state = DONE;
            end
            DONE: dif.flushed = 1'b1;
            default: next_state = IDLE;
        endcase
    end

    // Line storage, LRU ages, fill/writeback counters and the flush walk pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= WAY_W'(w);
                    for (int k = 0; k < WORDS; k++) data_q[s][w][k] <= '0;
                end
            end
            hitcount_q  <= '0;
            miss_flag_q <= 1'b0;
            victim_q    <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            ctr_q       <= '0;
            fset_q      <= '0;
            fway_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dif.halt) begin
                        fset_q <= '0;
                        fway_q <= '0;
                        ctr_q  <= '0;
                    end else if (req) begin
                        if (hit) begin
                            if (dif.dmemWEN) begin
                                data_q[req_idx][hit_way][req_off] <= dif.dmemstore;
                                dirty_q[req_idx][hit_way]         <= 1'b1;
                            end
                            if (WAYS > 1) begin
                                for (int w = 0; w < WAYS; w++) begin
                                    if (WAY_W'(w) == hit_way)
                                        age_q[req_idx][w] <= '0;
                                    else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                                        age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                                end
                            end
                            if (!miss_flag_q) hitcount_q <= hitcount_q + 32'd1;
                            miss_flag_q <= 1'b0;
                        end else begin
                            miss_flag_q <= 1'b1;
                            victim_q    <= victim;
                            miss_tag_q  <= req_tag;
                            miss_idx_q  <= req_idx;
                            ctr_q       <= '0;
                        end
                    end
                end
                WB: begin
                    if (!dif.dwait) ctr_q <= last_word ? '0 : ctr_q + 1'b1;
                end
                FETCH: begin
                    if (!dif.dwait) begin
                        data_q[miss_idx_q][victim_q][ctr_q] <= dif.dload;
                        ctr_q <= last_word ? '0 : ctr_q + 1'b1;
                        if (last_word) begin
                            tag_q[miss_idx_q][victim_q]   <= miss_tag_q;
                            valid_q[miss_idx_q][victim_q] <= 1'b1;
                            dirty_q[miss_idx_q][victim_q] <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (!fdirty || (!dif.dwait && last_word)) begin
                        if (fdirty) dirty_q[fset_q][fway_q] <= 1'b0;
                        ctr_q <= '0;
                        if (fway_q == WAY_W'(WAYS - 1)) begin
                            fway_q <= '0;
                            fset_q <= fset_q + 1'b1;
                        end else begin
                            fway_q <= fway_q + 1'b1;
                        end
                    end else if (!dif.dwait) begin
                        ctr_q <= ctr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
